// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU control codes, FSM state encoding and the
//               shift-operation predicate for the iterative ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_iterative_if
// Description : Request/response handshake bundle for the iterative ALU.
//               master = requester side, slave = ALU side.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_logic_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_logic_unit
// Description : Combinational evaluation of all single-cycle ALU operations.
//               Shifts are evaluated here only when ALU_BARREL_SHIFT_EN is
//               defined; otherwise shift codes yield 0 and the caller
//               performs them iteratively. Illegal codes yield 0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [3:0]       i_op,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_result
);

`ifdef ALU_BARREL_SHIFT_EN
    localparam int c_SHAMT_W = $clog2(WIDTH);
    logic [c_SHAMT_W-1:0] w_shamt;
    assign w_shamt = i_b[c_SHAMT_W-1:0];
`endif

    // Select the operation result from the control code
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
`ifdef ALU_BARREL_SHIFT_EN
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
`endif
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : alu_iterative
// Description : Multi-cycle ALU execute stage with valid/ready handshake.
//               Non-shift ops complete in one cycle; shifts step one bit per
//               cycle. Build option ALU_BARREL_SHIFT_EN makes every shift
//               single-cycle and removes the SHIFT state and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iterative
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    alu_iterative_if.slave bus
);

    logic [WIDTH-1:0] w_alu_result;
    logic             w_accept;
    alu_state_t       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

`ifndef ALU_BARREL_SHIFT_EN
    localparam int c_SHAMT_W = $clog2(WIDTH);
    logic [c_SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]     w_step;
    logic [WIDTH-1:0]     r_work;
    logic [c_SHAMT_W-1:0] r_count;
    logic [3:0]           r_op;

    assign w_shamt = bus.SrcB[c_SHAMT_W-1:0];

    // One-bit shift of the working register in the latched direction
    always_comb begin
        w_step = r_work;
        case (r_op)
            ALU_SLL: w_step = {r_work[WIDTH-2:0], 1'b0};
            ALU_SRL: w_step = {1'b0, r_work[WIDTH-1:1]};
            ALU_SRA: w_step = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_step = r_work;
        endcase
    end
`endif

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_logic (
        .i_op     (bus.ALUControl),
        .i_a      (bus.SrcA),
        .i_b      (bus.SrcB),
        .o_result (w_alu_result)
    );

    assign w_accept      = bus.in_valid && (r_state == IDLE);
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;

    // Control FSM: accept, optional bit-serial shifting, result hold until handoff
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            r_work      <= '0;
            r_count     <= '0;
            r_op        <= ALU_ADD;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
`ifndef ALU_BARREL_SHIFT_EN
                        if (is_shift_op(bus.ALUControl)) begin
                            r_work  <= bus.SrcA;
                            r_count <= w_shamt;
                            r_op    <= bus.ALUControl;
                            if (w_shamt == '0) begin
                                // Zero-distance shift passes the operand through
                                r_result    <= bus.SrcA;
                                r_zero      <= (bus.SrcA == '0);
                                r_out_valid <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_state <= SHIFT;
                            end
                        end else begin
                            r_result    <= w_alu_result;
                            r_zero      <= (w_alu_result == '0);
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end
`else
                        r_result    <= w_alu_result;
                        r_zero      <= (w_alu_result == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                SHIFT: begin
                    r_work  <= w_step;
                    r_count <= r_count - 1'b1;
                    // The last step publishes straight into the result register
                    if (r_count == c_SHAMT_W'(1)) begin
                        r_result    <= w_step;
                        r_zero      <= (w_step == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_iterative
// Description : Self-checking bench for alu_iterative: directed corner cases
//               plus randomized operations against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_iterative;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_iterative_if #(.WIDTH(WIDTH)) bus();

    alu_iterative #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result straight from the operation definitions
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % WIDTH;
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op == 4'b0110 || op == 4'b0111 || op == 4'b1000)
            return 1 + int'(b % WIDTH);
        return 1;
`endif
    endfunction

    // One full transaction: accept, wait for result, hold, handoff
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        logic [31:0] exp;
        int          lat;
        int          exp_lat;
        exp     = ref_alu(op, a, b);
        exp_lat = ref_lat(op, b);
        lat = 0;
        while (!bus.in_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'($urandom);
        lat = 1;
        while (!bus.out_valid && lat <= WIDTH + 4) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_lat"},  64'(lat), 64'(exp_lat));
        check({tag, "_vld"},  64'(bus.out_valid), 64'd1);
        check({tag, "_res"},  64'(bus.ALUResult), 64'(exp));
        check({tag, "_zero"}, 64'(bus.Zero), 64'(exp == 32'd0));
        check({tag, "_busy"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({tag, "_hold_res"},  64'(bus.ALUResult), 64'(exp));
            check({tag, "_hold_zero"}, 64'(bus.Zero), 64'(exp == 32'd0));
            check({tag, "_hold_vld"},  64'(bus.out_valid), 64'd1);
            check({tag, "_hold_rdy"},  64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_vld"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_post_rdy"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_post_res"}, 64'(bus.ALUResult), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        bus.ALUControl = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_rdy",  64'(bus.in_ready), 64'd1);
        check("rst_vld",  64'(bus.out_valid), 64'd0);
        check("rst_res",  64'(bus.ALUResult), 64'd0);
        check("rst_zero", 64'(bus.Zero), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_op(ALU_ADD,  32'd5,          32'd7,          0, "add_5_7");
        run_op(ALU_SUB,  32'd7,          32'd7,          0, "sub_7_7");
        run_op(ALU_ADD,  32'hFFFF_FFFF,  32'd1,          0, "add_wrap");
        run_op(ALU_SLT,  32'hFFFF_FFFF,  32'd1,          0, "slt");
        run_op(ALU_SLTU, 32'hFFFF_FFFF,  32'd1,          0, "sltu");
        run_op(4'b1011,  32'h1234_5678,  32'h9ABC_DEF0,  0, "illegal");
        run_op(ALU_SRA,  32'h8000_0000,  32'd4,          0, "sra4");
        run_op(ALU_SLL,  32'hDEAD_BEEF,  32'h0000_0020,  0, "sll0");
        run_op(ALU_SRL,  32'h8000_0001,  32'd31,         0, "srl31");
        run_op(ALU_XOR,  32'hA5A5_A5A5,  32'h5A5A_5A5A,  3, "bp_xor");

        // Reset in the middle of a long shift discards it
        bus.ALUControl = ALU_SLL;
        bus.SrcA       = 32'h0000_0001;
        bus.SrcB       = 32'd20;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_vld",  64'(bus.out_valid), 64'd0);
        check("midrst_rdy",  64'(bus.in_ready), 64'd1);
        check("midrst_res",  64'(bus.ALUResult), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(ALU_ADD, 32'd1, 32'd1, 0, "post_rst_add");

        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            run_op(op, a, b, int'($urandom_range(0, 3)), $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
